neuron_feeder: RTL and testbench

Front-end driver for one `neuron` instance, on the producer side of the neuron's `in_rdy`/`data_in_0..6` interface. It accepts seven words one per handshake from an upstream stream and holds them steady on the neuron's seven data inputs. It sequences the neuron's `reset` and `in_rdy` through one job, waits for `neu_rdy` under a watchdog, and returns the captured `neu_out` on a valid/ready result port. It sits between the layer scheduler and each neuron.

---
 rtl/neuron_feeder_pkg.sv | 17 +
 rtl/feed_buf.sv | 30 +++
 rtl/neuron_feeder.sv | 125 ++++++++++++
 tb/tb_neuron_feeder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_feeder_pkg.sv
// Shared definitions for the neuron feeder: word width, operand count and
// the feeder FSM state encoding.
package neuron_feeder_pkg;

   localparam int WORD_DATA_W = 32;
   localparam int NEU_IN_NUM  = 7;

   typedef logic [WORD_DATA_W-1:0] word_data_bus_t;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } feed_state_t;

endpackage

// File: rtl/feed_buf.sv
// Operand buffer: seven word registers written one at a time by index,
// presented in parallel to the neuron data inputs.
module feed_buf
   import neuron_feeder_pkg::*;
#(
   parameter int WIDTH = WORD_DATA_W
) (
   input  logic                                clk,
   input  logic                                clr,
   input  logic                                we,
   input  logic [2:0]                          idx,
   input  logic [WIDTH-1:0]                    wdata,
   output logic [NEU_IN_NUM-1:0][WIDTH-1:0]    q
);

   // Indexed slot write with synchronous clear of every slot.
   // NOTE: non-blocking assignments keep register updates order-independent
   // across processes; the slots are cleared on reset because they drive the
   // neuron inputs directly and must not expose stale operands.
   always_ff @(posedge clk) begin
      if (clr) begin
         q <= '0;
      end else if (we) begin
         for (int i = 0; i < NEU_IN_NUM; i++) begin
            if (idx == 3'(i)) q[i] <= wdata;
         end
      end
   end

endmodule

// File: rtl/neuron_feeder.sv
// Producer-side driver for one neuron: collects seven operands, sequences
// the neuron reset/in_rdy through a job under a watchdog, and returns the
// result (or a timeout error) on a valid/ready port.
module neuron_feeder
   import neuron_feeder_pkg::*;
#(
   parameter int WIDTH   = WORD_DATA_W,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             neu_reset,
   output logic             neu_in_rdy,
   output logic [WIDTH-1:0] neu_data_0,
   output logic [WIDTH-1:0] neu_data_1,
   output logic [WIDTH-1:0] neu_data_2,
   output logic [WIDTH-1:0] neu_data_3,
   output logic [WIDTH-1:0] neu_data_4,
   output logic [WIDTH-1:0] neu_data_5,
   output logic [WIDTH-1:0] neu_data_6,
   input  logic [WIDTH-1:0] neu_out,
   input  logic             neu_rdy,
   output logic [WIDTH-1:0] res_data,
   output logic             res_err,
   output logic             res_valid,
   input  logic             res_ready
);

   localparam int WDOG_W = $clog2(TIMEOUT + 1);

   feed_state_t                           state, state_next;
   logic [2:0]                            cnt;
   logic [WDOG_W-1:0]                     wdog;
   logic [NEU_IN_NUM-1:0][WIDTH-1:0]      slot_q;
   logic                                  load_accept;
   logic                                  wdog_last;

   assign load_accept = s_valid && (state == ST_LOAD);
   assign wdog_last   = (wdog == WDOG_W'(TIMEOUT - 1));

   feed_buf #(.WIDTH(WIDTH)) u_feed_buf (
      .clk   (clk),
      .clr   (reset),
      .we    (load_accept),
      .idx   (cnt),
      .wdata (s_data),
      .q     (slot_q)
   );

   assign neu_data_0 = slot_q[0];
   assign neu_data_1 = slot_q[1];
   assign neu_data_2 = slot_q[2];
   assign neu_data_3 = slot_q[3];
   assign neu_data_4 = slot_q[4];
   assign neu_data_5 = slot_q[5];
   assign neu_data_6 = slot_q[6];

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_LOAD;
      else       state <= state_next;
   end

   // Next-state logic; handshake/neuron controls decode from state alone.
   // NOTE: every output gets a default first so no path infers a latch.
   always_comb begin
      state_next = state;
      s_ready    = 1'b0;
      neu_reset  = 1'b1;
      neu_in_rdy = 1'b0;
      res_valid  = 1'b0;
      case (state)
         ST_LOAD: begin
            s_ready   = 1'b1;
            neu_reset = 1'b0;
            if (s_valid && cnt == 3'd6) state_next = ST_ARM;
         end
         ST_ARM: begin
            state_next = ST_RUN;
         end
         ST_RUN: begin
            neu_in_rdy = 1'b1;
            if (neu_rdy || wdog_last) state_next = ST_DONE;
         end
         ST_DONE: begin
            neu_in_rdy = 1'b1;
            res_valid  = 1'b1;
            if (res_ready) state_next = ST_LOAD;
         end
         default: state_next = ST_LOAD;
      endcase
   end

   // Operand index and RUN watchdog.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= 3'd0;
         wdog <= '0;
      end else begin
         if (load_accept) cnt <= (cnt == 3'd6) ? 3'd0 : cnt + 3'd1;
         if (state == ST_ARM)      wdog <= '0;
         else if (state == ST_RUN) wdog <= wdog + 1'b1;
      end
   end

   // Result capture on RUN exit; a late neu_rdy still beats the timeout.
   always_ff @(posedge clk) begin
      if (reset) begin
         res_data <= '0;
         res_err  <= 1'b0;
      end else if (state == ST_RUN) begin
         if (neu_rdy) begin
            res_data <= neu_out;
            res_err  <= 1'b0;
         end else if (wdog_last) begin
            res_data <= '0;
            res_err  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_neuron_feeder.sv
// Self-checking bench for neuron_feeder: directed job table, hand-written
// reset sequences, then randomized jobs scored against a job-level model.
module tb_neuron_feeder;
   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 64;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] s_data;
   logic             s_valid;
   logic             s_ready;
   logic             neu_reset;
   logic             neu_in_rdy;
   logic [WIDTH-1:0] neu_data_0, neu_data_1, neu_data_2, neu_data_3;
   logic [WIDTH-1:0] neu_data_4, neu_data_5, neu_data_6;
   logic [WIDTH-1:0] neu_out;
   logic             neu_rdy;
   logic [WIDTH-1:0] res_data;
   logic             res_err;
   logic             res_valid;
   logic             res_ready;

   logic [WIDTH-1:0] nd [7];
   assign nd[0] = neu_data_0;
   assign nd[1] = neu_data_1;
   assign nd[2] = neu_data_2;
   assign nd[3] = neu_data_3;
   assign nd[4] = neu_data_4;
   assign nd[5] = neu_data_5;
   assign nd[6] = neu_data_6;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [6:0][31:0] w;
      logic [6:0][3:0]  gap;
      int               lat;    // RUN cycle carrying neu_rdy; 0 = never
      logic [31:0]      nout;
      int               bp;     // DONE cycles with res_ready low
      logic [31:0]      exp_d;
      logic             exp_e;
      int               exp_run;
   } vec_t;

   vec_t vecs [6];

   neuron_feeder #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .neu_reset(neu_reset), .neu_in_rdy(neu_in_rdy),
      .neu_data_0(neu_data_0), .neu_data_1(neu_data_1),
      .neu_data_2(neu_data_2), .neu_data_3(neu_data_3),
      .neu_data_4(neu_data_4), .neu_data_5(neu_data_5),
      .neu_data_6(neu_data_6), .neu_out(neu_out), .neu_rdy(neu_rdy),
      .res_data(res_data), .res_err(res_err), .res_valid(res_valid),
      .res_ready(res_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Job-level reference: result is the neuron value if it answers within
   // TIMEOUT RUN cycles, else an error with zero data after TIMEOUT cycles.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      if (v.lat >= 1 && v.lat <= TIMEOUT) begin
         r.exp_d = v.nout; r.exp_e = 1'b0; r.exp_run = v.lat;
      end else begin
         r.exp_d = '0;     r.exp_e = 1'b1; r.exp_run = TIMEOUT;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_s_ready"},    s_ready,    1);
      check({tag, "_neu_reset"},  neu_reset,  0);
      check({tag, "_neu_in_rdy"}, neu_in_rdy, 0);
      check({tag, "_res_valid"},  res_valid,  0);
   endtask

   task automatic check_slots(input string tag, input logic [6:0][31:0] w);
      for (int i = 0; i < 7; i++) check({tag, "_slot"}, nd[i], w[i]);
   endtask

   task automatic feed_words(input int n);
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1; s_data = $urandom;
         tick();
      end
      s_valid = 1'b0;
   endtask

   task automatic do_job(input vec_t v);
      int  k;
      int  waits;
      bit  got;
      for (int i = 0; i < 7; i++) begin
         for (int g = 0; g < int'(v.gap[i]); g++) begin
            s_valid = 1'b0; neu_rdy = 1'b1; neu_out = $urandom;
            check("load_gap_s_ready", s_ready, 1);
            tick();
            check("load_gap_res_valid", res_valid, 0);
         end
         neu_rdy = 1'b0;
         s_valid = 1'b1; s_data = v.w[i];
         waits = 0;
         while (!s_ready && waits < 20) begin tick(); waits++; end
         check("load_s_ready", s_ready, 1);
         tick();
      end
      s_valid = 1'b0; s_data = $urandom;
      // ARM cycle, with a stray neu_rdy that must be ignored
      check("arm_neu_reset", neu_reset, 1);
      check("arm_neu_in_rdy", neu_in_rdy, 0);
      check("arm_s_ready", s_ready, 0);
      check_slots("arm", v.w);
      neu_rdy = 1'b1; neu_out = $urandom;
      tick();
      neu_rdy = 1'b0;
      check("run_neu_in_rdy", neu_in_rdy, 1);
      check("run_res_valid", res_valid, 0);
      k = 1; got = 1'b0;
      while (!got && k <= TIMEOUT + 4) begin
         neu_rdy = (k == v.lat);
         neu_out = (k == v.lat) ? v.nout : $urandom;
         tick();
         neu_rdy = 1'b0; neu_out = $urandom;
         if (res_valid) got = 1'b1;
         else k++;
      end
      check("done_res_valid", res_valid, 1);
      check("run_cycles", k, v.exp_run);
      check("done_res_data", res_data, v.exp_d);
      check("done_res_err", res_err, v.exp_e);
      // DONE under backpressure with a word offered that must wait
      res_ready = 1'b0; s_valid = 1'b1; s_data = $urandom;
      for (int b = 0; b < v.bp; b++) begin
         tick();
         check("bp_res_valid", res_valid, 1);
         check("bp_res_data", res_data, v.exp_d);
         check("bp_res_err", res_err, v.exp_e);
         check("bp_s_ready", s_ready, 0);
         check("bp_neu_in_rdy", neu_in_rdy, 1);
         check_slots("bp", v.w);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0; s_valid = 1'b0;
      check_idle_outputs("post_done");
   endtask

   function automatic vec_t rand_vec(input int lat);
      vec_t v;
      for (int i = 0; i < 7; i++) begin
         v.w[i]   = $urandom;
         v.gap[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
      end
      v.lat  = lat;
      v.nout = $urandom;
      v.bp   = $urandom_range(0, 3);
      return model(v);
   endfunction

   initial begin
      reset = 1'b1; s_valid = 1'b0; s_data = '0;
      neu_out = '0; neu_rdy = 1'b0; res_ready = 1'b0;

      vecs[0] = '{w: {32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1},
                  gap: '0, lat: 11, nout: 32'hA5, bp: 0,
                  exp_d: 32'hA5, exp_e: 1'b0, exp_run: 11};
      vecs[1] = '{w: {32'h17, 32'h16, 32'h15, 32'h14, 32'h13, 32'h12, 32'h11},
                  gap: {4'd3, 4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd0},
                  lat: 3, nout: 32'hDEADBEEF, bp: 0,
                  exp_d: 32'hDEADBEEF, exp_e: 1'b0, exp_run: 3};
      vecs[2] = '{w: {32'h27, 32'h26, 32'h25, 32'h24, 32'h23, 32'h22, 32'h21},
                  gap: '0, lat: 1, nout: 32'h12345678, bp: 5,
                  exp_d: 32'h12345678, exp_e: 1'b0, exp_run: 1};
      vecs[3] = '{w: {32'h37, 32'h36, 32'h35, 32'h34, 32'h33, 32'h32, 32'h31},
                  gap: '0, lat: 0, nout: 32'hCAFEF00D, bp: 1,
                  exp_d: 32'h0, exp_e: 1'b1, exp_run: 64};
      vecs[4] = '{w: {32'h47, 32'h46, 32'h45, 32'h44, 32'h43, 32'h42, 32'h41},
                  gap: '0, lat: 64, nout: 32'h0BADF00D, bp: 0,
                  exp_d: 32'h0BADF00D, exp_e: 1'b0, exp_run: 64};
      vecs[5] = '{w: {32'h57, 32'h56, 32'h55, 32'h54, 32'h53, 32'h52, 32'h51},
                  gap: '0, lat: 65, nout: 32'h55AA55AA, bp: 2,
                  exp_d: 32'h0, exp_e: 1'b1, exp_run: 64};

      // reset state
      tick(); tick();
      check_idle_outputs("reset");
      check("reset_res_data", res_data, 0);
      check("reset_res_err", res_err, 0);
      check_slots("reset", '0);
      reset = 1'b0;

      // directed job table
      for (int t = 0; t < 6; t++) do_job(vecs[t]);

      // reset after four words: job discarded, next seven form a clean job
      feed_words(4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle_outputs("rst_load");
      check_slots("rst_load", '0);
      do_job(rand_vec(5));

      // reset during RUN: neuron released, no result ever appears
      feed_words(7);
      tick(); tick(); tick();
      check("pre_rst_neu_in_rdy", neu_in_rdy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle_outputs("rst_run");
      check("rst_run_res_data", res_data, 0);
      neu_rdy = 1'b1; neu_out = $urandom;
      tick(); tick();
      neu_rdy = 1'b0;
      check("rst_run_stray_res_valid", res_valid, 0);
      check("rst_run_stray_s_ready", s_ready, 1);
      do_job(rand_vec(2));

      // randomized jobs against the reference model
      for (int r = 0; r < 20; r++) do_job(rand_vec($urandom_range(0, 70)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
